fifo_stream_reader: RTL and testbench

// - Read-side drain engine for the team's synchronous show-ahead FIFO (pop via rd_en/empty).
// - Converts the FIFO pop interface into a valid/ready output stream with burst framing (out_last).
// - Sits between a FIFO read port and a downstream consumer.
// - 2-entry registered skid buffer: no combinational path from out_ready to fifo_rd_en.

---
 rtl/fifo_stream_reader_if.sv | 23 ++
 rtl/fifo_stream_reader.sv | 97 +++++++++
 tb/tb_fifo_stream_reader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port and valid/ready output stream bundled for fifo_stream_reader.
// master = the reader engine, slave = FIFO plus downstream consumer.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        input  fifo_empty, fifo_rd_data, out_ready,
        output fifo_rd_en, out_valid, out_data, out_last
    );

    modport slave (
        output fifo_empty, fifo_rd_data, out_ready,
        input  fifo_rd_en, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Show-ahead FIFO drain engine: 2-entry registered skid buffer with burst framing.
// Optional FIFO_READER_CNT_EN adds the beat_total accepted-beat counter port.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 drain_en,
    fifo_stream_reader_if.master bus
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [31:0]          beat_total
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fill_t;

    localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

    fill_t                 state, state_next;
    logic [DATA_WIDTH-1:0] head, tail, head_next, tail_next;
    logic [15:0]           bidx;
    logic                  pop, accept, valid;

    // Pop decision uses only registered fill state, so out_ready never reaches fifo_rd_en.
    assign pop    = drain_en & ~bus.fifo_empty & (state != TWO) & ~reset;
    assign valid  = (state != EMPTY);
    assign accept = valid & bus.out_ready;

    assign bus.fifo_rd_en = pop;
    assign bus.out_valid  = valid;
    assign bus.out_data   = head;
    assign bus.out_last   = valid & (bidx == LAST_IDX);

    always_comb begin
        state_next = state;
        head_next  = head;
        tail_next  = tail;
        case (state)
            EMPTY: begin
                if (pop) begin
                    head_next  = bus.fifo_rd_data;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (pop && accept) begin
                    head_next = bus.fifo_rd_data;
                end else if (pop) begin
                    tail_next  = bus.fifo_rd_data;
                    state_next = TWO;
                end else if (accept) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (accept) begin
                    head_next  = tail;
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
            bidx  <= '0;
        end else begin
            state <= state_next;
            head  <= head_next;
            tail  <= tail_next;
            if (accept) begin
                bidx <= (bidx == LAST_IDX) ? '0 : bidx + 16'd1;
            end
        end
    end

`ifdef FIFO_READER_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_total <= '0;
        end else if (accept) begin
            beat_total <= beat_total + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: queue-based reference model checked every cycle,
// plus directed phases with hand-computed expectations.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int BL = 4;

    logic clock = 1'b0;
    logic reset;
    logic drain_en;
    logic empty_mask;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

`ifdef FIFO_READER_CNT_EN
    logic [31:0] beat_total;
    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clock(clock), .reset(reset), .drain_en(drain_en), .bus(bus), .beat_total(beat_total)
    );
`else
    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clock(clock), .reset(reset), .drain_en(drain_en), .bus(bus)
    );
`endif

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] src[$];     // words waiting in the emulated FIFO
    logic [DW-1:0] model[$];   // words popped but not yet accepted
    logic [DW-1:0] log_d[$];
    bit            log_l[$];
    int            log_c[$];
    int            pop_c[$];
    int            acc_cnt = 0;
    logic [31:0]   total   = '0;
    int            cycle   = 0;
    int            pop_count = 0;
    bit            exp_pop, exp_acc, exp_valid, exp_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: skid contents are exactly the popped-but-unaccepted words, capacity 2.
    always begin
        @(negedge clock);
        if (reset) begin
            model.delete();
            acc_cnt = 0;
            total   = '0;
            exp_pop = 1'b0;
            exp_acc = 1'b0;
            chk("reset_rd_en", 32'(bus.fifo_rd_en), 32'd0);
            chk("reset_valid", 32'(bus.out_valid), 32'd0);
            chk("reset_data", 32'(bus.out_data), 32'd0);
            chk("reset_last", 32'(bus.out_last), 32'd0);
`ifdef FIFO_READER_CNT_EN
            chk("reset_beat_total", beat_total, 32'd0);
`endif
        end else begin
            exp_valid = (model.size() != 0);
            exp_rd    = drain_en & ~bus.fifo_empty & (model.size() < 2);
            chk("rd_en", 32'(bus.fifo_rd_en), 32'(exp_rd));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("out_data", 32'(bus.out_data), 32'(model[0]));
                chk("out_last", 32'(bus.out_last), 32'((acc_cnt % BL) == BL - 1));
            end
`ifdef FIFO_READER_CNT_EN
            chk("beat_total", beat_total, total);
`endif
            exp_pop = exp_rd;
            exp_acc = exp_valid & bus.out_ready;
        end
        @(posedge clock);
        cycle++;
        if (exp_acc) begin
            log_d.push_back(model.pop_front());
            log_l.push_back((acc_cnt % BL) == BL - 1);
            log_c.push_back(cycle);
            acc_cnt++;
            total = total + 32'd1;
        end
        if (exp_pop) begin
            model.push_back(src.pop_front());
            pop_c.push_back(cycle);
            pop_count++;
        end
    end

    task automatic refresh();
        bus.fifo_empty   = (src.size() == 0) || empty_mask;
        bus.fifo_rd_data = (src.size() != 0) ? src[0] : '0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            refresh();
        end
    endtask

    task automatic drain_wait(input string nm, input int budget);
        int k = 0;
        while ((src.size() != 0 || model.size() != 0) && k < budget) begin
            cyc(1);
            k++;
        end
        chk({nm, "_timeout"}, 32'(k < budget), 32'd1);
    endtask

    task automatic clear_logs();
        log_d.delete();
        log_l.delete();
        log_c.delete();
        pop_c.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] ref_words[$];
        int p0;
        int lasts;

        reset         = 1'b1;
        drain_en      = 1'b1;
        empty_mask    = 1'b0;
        bus.out_ready = 1'b1;
        src.push_back(8'hAA);
        refresh();

        // Reset with FIFO non-empty: pop strobe held off
        cyc(3);
        chk("T1_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("T1_valid", 32'(bus.out_valid), 32'd0);
        chk("T1_data", 32'(bus.out_data), 32'd0);
        src.delete();
        refresh();
        cyc(1);
        reset = 1'b0;
        cyc(2);

        // Back-to-back 0x01..0x08 with ready high
        clear_logs();
        for (int i = 1; i <= 8; i++) src.push_back(8'(i));
        refresh();
        drain_wait("T2", 50);
        chk("T2_count", 32'(log_d.size()), 32'd8);
        if (log_d.size() == 8 && pop_c.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("T2_data", 32'(log_d[i]), 32'(i + 1));
                chk("T2_last", 32'(log_l[i]), 32'(i == 3 || i == 7));
                chk("T2_gapless", 32'(log_c[i]), 32'(pop_c[0] + 1 + i));
            end
        end

        // Consumer stall: two pops fill the skid, then strobe stops
        clear_logs();
        bus.out_ready = 1'b0;
        p0 = pop_count;
        for (int i = 0; i < 4; i++) src.push_back(8'(8'h10 + i));
        refresh();
        cyc(5);
        chk("T3_pops", 32'(pop_count - p0), 32'd2);
        chk("T3_hold_data", 32'(bus.out_data), 32'h10);
        chk("T3_rd_en_off", 32'(bus.fifo_rd_en), 32'd0);
        bus.out_ready = 1'b1;
        drain_wait("T3", 50);
        chk("T3_count", 32'(log_d.size()), 32'd4);
        if (log_d.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("T3_data", 32'(log_d[i]), 32'(8'h10 + i));
                chk("T3_gapless", 32'(log_c[i]), 32'(log_c[0] + i));
            end
        end

        // drain_en dropped after two pops; burst resumes on the 3rd beat
        clear_logs();
        for (int i = 0; i < 4; i++) src.push_back(8'(8'h20 + i));
        refresh();
        cyc(2);
        drain_en = 1'b0;
        cyc(4);
        chk("T4_valid_off", 32'(bus.out_valid), 32'd0);
        chk("T4_delivered", 32'(log_d.size()), 32'd2);
        chk("T4_bidx", 32'(acc_cnt % BL), 32'd2);
        drain_en = 1'b1;
        drain_wait("T4", 50);
        chk("T4_count", 32'(log_d.size()), 32'd4);
        if (log_d.size() == 4) begin
            chk("T4_beat3", 32'(log_d[2]), 32'h22);
            chk("T4_beat3_last", 32'(log_l[2]), 32'd0);
            chk("T4_beat4", 32'(log_d[3]), 32'h23);
            chk("T4_beat4_last", 32'(log_l[3]), 32'd1);
        end

        // Random ready / empty pattern over 1000 words
        clear_logs();
        ref_words.delete();
        for (int i = 0; i < 1000; i++) begin
            logic [DW-1:0] w;
            w = 8'($urandom);
            src.push_back(w);
            ref_words.push_back(w);
        end
        refresh();
        for (int k = 0; k < 20000 && (src.size() != 0 || model.size() != 0); k++) begin
            bus.out_ready = ($urandom_range(0, 2) != 0);
            empty_mask    = ($urandom_range(0, 3) == 0);
            cyc(1);
        end
        bus.out_ready = 1'b1;
        empty_mask    = 1'b0;
        refresh();
        drain_wait("T5", 100);
        chk("T5_count", 32'(log_d.size()), 32'd1000);
        lasts = 0;
        if (log_d.size() == 1000) begin
            for (int i = 0; i < 1000; i++) begin
                if (log_d[i] !== ref_words[i]) chk("T5_order", 32'(log_d[i]), 32'(ref_words[i]));
                if (log_l[i]) lasts++;
            end
        end
        chk("T5_lasts", 32'(lasts), 32'd250);

        // Fresh reset, 10 beats, then reset mid-stream
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        clear_logs();
        for (int i = 0; i < 10; i++) src.push_back(8'(8'h40 + i));
        refresh();
        drain_wait("T6a", 50);
        chk("T6_accepts", 32'(log_d.size()), 32'd10);
`ifdef FIFO_READER_CNT_EN
        chk("T6_beat_total_10", beat_total, 32'd10);
`endif
        for (int i = 0; i < 16; i++) src.push_back(8'(8'h50 + i));
        refresh();
        bus.out_ready = 1'b0;
        cyc(2);
        bus.out_ready = 1'b1;
        cyc(3);
        reset = 1'b1;
        cyc(2);
`ifdef FIFO_READER_CNT_EN
        chk("T6_beat_total_rst", beat_total, 32'd0);
`endif
        chk("T6_rst_valid", 32'(bus.out_valid), 32'd0);
        reset = 1'b0;
        clear_logs();
        drain_wait("T6b", 80);
        if (log_d.size() >= 4) begin
            chk("T6_new_burst_b0", 32'(log_l[0]), 32'd0);
            chk("T6_new_burst_b2", 32'(log_l[2]), 32'd0);
            chk("T6_new_burst_b3", 32'(log_l[3]), 32'd1);
        end else begin
            chk("T6_after_reset_beats", 32'(log_d.size()), 32'd4);
        end
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
